// File: rtl/demux2_pipe.sv
// demux2_pipe: registered 1-to-2 demultiplexer with valid/ready handshake and per-branch delivery counters
module demux2_pipe #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 i_valid_in,
  input  logic [BUS_WIDTH-1:0] i_data_in,
  input  logic                 sel_in,
  output logic                 i_ready_out,
  output logic                 y0_valid_out,
  output logic [BUS_WIDTH-1:0] y0_data_out,
  input  logic                 y0_ready_in,
  output logic                 y1_valid_out,
  output logic [BUS_WIDTH-1:0] y1_data_out,
  input  logic                 y1_ready_in,
  output logic [CNT_WIDTH-1:0] cnt0_out,
  output logic [CNT_WIDTH-1:0] cnt1_out
);
  typedef enum logic {EMPTY, FULL} slot_t;
  slot_t                st  [2];
  logic [BUS_WIDTH-1:0] dat [2];
  logic [CNT_WIDTH-1:0] cnt [2];
  logic [1:0]           acc, drn;
  logic                 accept;
  assign i_ready_out = sel_in ? (st[1] == EMPTY || y1_ready_in) : (st[0] == EMPTY || y0_ready_in);
  assign accept      = i_valid_in && i_ready_out;
  assign acc         = {accept && sel_in, accept && !sel_in};
  assign drn         = {st[1] == FULL && y1_ready_in, st[0] == FULL && y0_ready_in};
  // Each slot loads on accept (even while draining), empties on drain alone, and counts handshakes
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in)
      for (int k = 0; k < 2; k++) begin
        st[k]  <= EMPTY;
        dat[k] <= '0;
        cnt[k] <= '0;
      end
    else
      for (int k = 0; k < 2; k++) begin
        st[k] <= acc[k] ? FULL : drn[k] ? EMPTY : st[k];
        if (acc[k]) dat[k] <= i_data_in;
        if (drn[k]) cnt[k] <= cnt[k] + 1'b1;
      end
  assign y0_valid_out = st[0] == FULL;
  assign y1_valid_out = st[1] == FULL;
  assign y0_data_out  = dat[0];
  assign y1_data_out  = dat[1];
  assign cnt0_out     = cnt[0];
  assign cnt1_out     = cnt[1];
endmodule

// File: tb/tb_demux2_pipe.sv
// tb_demux2_pipe: directed and random checks of demux2_pipe against a per-branch slot model
module tb_demux2_pipe;
  logic        clk = 0, rst_n = 0;
  logic        i_valid = 0, sel = 0, i_ready;
  logic [31:0] i_data = 0;
  logic        y0_valid, y1_valid, y0_ready = 0, y1_ready = 0;
  logic [31:0] y0_data, y1_data;
  logic [15:0] cnt0, cnt1;
  int          total = 0, bad = 0;
  bit          m_full [2];
  logic [31:0] m_data [2];
  int unsigned m_cnt  [2];
  demux2_pipe dut (
    .clk_in(clk), .rst_n_in(rst_n), .i_valid_in(i_valid), .i_data_in(i_data), .sel_in(sel),
    .i_ready_out(i_ready), .y0_valid_out(y0_valid), .y0_data_out(y0_data), .y0_ready_in(y0_ready),
    .y1_valid_out(y1_valid), .y1_data_out(y1_data), .y1_ready_in(y1_ready),
    .cnt0_out(cnt0), .cnt1_out(cnt1)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_full[b] = 0;
      m_data[b] = 0;
      m_cnt[b]  = 0;
    end
  endtask
  task automatic chk_outs();
    chk("y0_valid", 32'(y0_valid), 32'(m_full[0]));
    chk("y1_valid", 32'(y1_valid), 32'(m_full[1]));
    chk("y0_data", y0_data, m_data[0]);
    chk("y1_data", y1_data, m_data[1]);
    chk("cnt0", 32'(cnt0), m_cnt[0]);
    chk("cnt1", 32'(cnt1), m_cnt[1]);
  endtask
  task automatic cyc(input bit v, input logic [31:0] d, input bit s, input bit r0, input bit r1);
    bit take [2];
    bit rdy, acc;
    i_valid = v; i_data = d; sel = s; y0_ready = r0; y1_ready = r1;
    #1;
    take[0] = r0;
    take[1] = r1;
    rdy = !m_full[s] || take[s];
    chk("i_ready", 32'(i_ready), 32'(rdy));
    acc = v && rdy;
    for (int b = 0; b < 2; b++) begin
      if (m_full[b] && take[b]) begin
        m_cnt[b]  = (m_cnt[b] + 1) % 65536;
        m_full[b] = 0;
      end
      if (acc && s == b[0]) begin
        m_full[b] = 1;
        m_data[b] = d;
      end
    end
    @(posedge clk);
    #1;
    chk_outs();
    @(negedge clk);
  endtask
  initial begin
    bit          hv, hs;
    logic [31:0] hd;
    int          guard;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_ready", 32'(i_ready), 32'd1);
    chk_outs();
    @(negedge clk);
    cyc(1, 32'hA5A5_0001, 0, 1, 0);
    chk("w1_on_y0", y0_data, 32'hA5A5_0001);
    cyc(1, 32'hA5A5_0002, 0, 1, 0);
    chk("w2_on_y0", y0_data, 32'hA5A5_0002);
    cyc(0, 0, 0, 1, 0);
    chk("cnt0_two", 32'(cnt0), 32'd2);
    chk("y1_never", 32'(y1_valid), 32'd0);
    cyc(1, 32'h1111, 0, 0, 0);
    cyc(1, 32'h2222, 0, 0, 0);
    chk("held_1111", y0_data, 32'h1111);
    i_valid = 1; i_data = 32'h2222; sel = 0;
    #1;
    chk("blocked_ready", 32'(i_ready), 32'd0);
    cyc(1, 32'h2222, 1, 0, 0);
    chk("y1_2222", y1_data, 32'h2222);
    chk("y0_still", y0_data, 32'h1111);
    cyc(1, 32'h3333, 0, 1, 0);
    chk("refill_valid", 32'(y0_valid), 32'd1);
    chk("refill_data", y0_data, 32'h3333);
    chk("refill_cnt0", 32'(cnt0), 32'd3);
    cyc(0, 0, 0, 1, 1);
    guard = 0;
    while (m_cnt[1] != 32'hFFFF && guard < 70000) begin
      cyc(1, $urandom, 1, 1, 1);
      guard++;
    end
    chk("wrap_reach", m_cnt[1], 32'hFFFF);
    chk("cnt1_max", 32'(cnt1), 32'hFFFF);
    cyc(0, 0, 0, 1, 1);
    chk("cnt1_wrap", 32'(cnt1), 32'd0);
    hv = 0; hs = 0; hd = 0;
    repeat (400) begin
      if (!hv) begin
        hv = 1'($urandom_range(0, 1));
        hs = 1'($urandom_range(0, 1));
        hd = $urandom;
      end
      cyc(hv, hd, hs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (hv && (!m_full[hs] || m_data[hs] == hd)) hv = 0;
    end
    cyc(0, 0, 0, 1, 1);
    cyc(1, 32'h5555, 1, 0, 0);
    chk("pre_rst_full", 32'(y1_valid), 32'd1);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    chk("async_y1v", 32'(y1_valid), 32'd0);
    chk("async_cnt1", 32'(cnt1), 32'd0);
    chk("async_y1d", y1_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (3) cyc(0, 0, 0, 1, 1);
    chk("no_redeliver", 32'(cnt1), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
